scb_wb_collector: RTL

- Write-back side consumer of the scoreboard's retire outputs (rd address plus pipe select).
- Each cycle, when the scoreboard names a finishing pipe, the block captures that pipe's result and the rd address into a 4-entry in-order write-back queue.
- It drains one entry per cycle into the register-file write port and provides youngest-match forwarding to the reservation station.
- It raises a full flag so the scoreboard withholds retirement.

---
 rtl/scb_wb_collector.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/scb_wb_collector.sv
// Write-back collector: captures the retiring pipe's result and rd address into a
// small in-order queue, drains it into the register-file write port, offers
// youngest-match forwarding to the reservation station, and flags full/overflow.
module scb_wb_collector #(
  parameter int              W_PA_REG    = 5,
  parameter int              W_PD_DATA   = 32,
  parameter int              W_PC_SEL_WB = 2,
  parameter int              S_depth     = 4,
  parameter int              W_ptr       = 2,
  parameter logic [W_PC_SEL_WB-1:0] V_unpip = 2'b00,
  parameter logic [W_PC_SEL_WB-1:0] V_pip0  = 2'b01,
  parameter logic [W_PC_SEL_WB-1:0] V_pip1  = 2'b10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W_PA_REG-1:0]    CDI_PA_rd,
  input  logic [W_PC_SEL_WB-1:0] CDI_PC_selwb,
  input  logic [W_PD_DATA-1:0]   CDI_PD_ex,
  input  logic [W_PD_DATA-1:0]   CDI_PD_mul,
  input  logic                   CDI_PC_rf_rdy,
  input  logic [W_PA_REG-1:0]    CDI_PA_rs,
  input  logic                   CFI_PC_clear,
  output logic                   CDO_PC_we,
  output logic [W_PA_REG-1:0]    CDO_PA_wa,
  output logic [W_PD_DATA-1:0]   CDO_PD_wd,
  output logic                   CDO_PC_full,
  output logic                   CDO_PC_fwd_hit,
  output logic [W_PD_DATA-1:0]   CDO_PD_fwd,
  output logic                   CDO_PC_ovf
);

  // Queue storage; entries beyond count are stale and never observed.
  logic [W_PA_REG-1:0]  rd_q   [S_depth];
  logic [W_PD_DATA-1:0] data_q [S_depth];

  logic [W_ptr-1:0] head;
  logic [W_ptr-1:0] tail;
  logic [W_ptr:0]   count;
  logic             ovf;

  logic                 sel_valid;
  logic [W_PD_DATA-1:0] sel_data;
  logic                 push_req;
  logic                 push_ok;
  logic                 pop;
  logic                 full;
  logic                 not_empty;
  logic [W_ptr-1:0]     slot;

  // Choose the result of whichever pipe the scoreboard says is retiring.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    case (CDI_PC_selwb)
      V_unpip: begin
        sel_valid = 1'b0;
        sel_data  = '0;
      end
      V_pip0: begin
        sel_valid = 1'b1;
        sel_data  = CDI_PD_ex;
      end
      V_pip1: begin
        sel_valid = 1'b1;
        sel_data  = CDI_PD_mul;
      end
      default: begin
        sel_valid = 1'b0;
        sel_data  = '0;
      end
    endcase
  end

  // x0 is hardwired, so writes to it never enter the queue.
  assign push_req  = sel_valid && (CDI_PA_rd != '0);
  assign not_empty = (count != '0);
  assign full      = (count == (W_ptr + 1)'(S_depth));
  assign pop       = not_empty && CDI_PC_rf_rdy;
  // A push into a full queue only fits when the head leaves in the same cycle.
  assign push_ok   = push_req && (!full || pop);

  // Head of queue drives the register-file write port directly.
  assign CDO_PC_we   = not_empty;
  assign CDO_PA_wa   = not_empty ? rd_q[head]   : '0;
  assign CDO_PD_wd   = not_empty ? data_q[head] : '0;
  assign CDO_PC_full = full;
  assign CDO_PC_ovf  = ovf;

  // Pointer, occupancy and sticky overflow bookkeeping; clear flushes but keeps ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (CFI_PC_clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        tail <= tail + W_ptr'(1);
      end
      if (pop) begin
        head <= head + W_ptr'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (W_ptr + 1)'(1);
        2'b01:   count <= count - (W_ptr + 1)'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

  // Entry payload write at the tail; storage needs no reset since count gates it.
  always_ff @(posedge clk) begin
    if (!rst && !CFI_PC_clear && push_ok) begin
      rd_q[tail]   <= CDI_PA_rd;
      data_q[tail] <= sel_data;
    end
  end

  // Scan oldest to youngest so the last match found is the youngest one.
  always_comb begin
    CDO_PC_fwd_hit = 1'b0;
    CDO_PD_fwd     = '0;
    slot           = '0;
    for (int i = 0; i < S_depth; i++) begin
      slot = head + W_ptr'(i);
      if (((W_ptr + 1)'(i) < count) && (rd_q[slot] == CDI_PA_rs) && (CDI_PA_rs != '0)) begin
        CDO_PC_fwd_hit = 1'b1;
        CDO_PD_fwd     = data_q[slot];
      end
    end
  end

endmodule
